// File: rtl/mult_div_sequencer_pkg.sv
// Shared constants for the iterative multiply/divide sequencer:
// ALU control codes, operation encodings, FSM state encodings and
// a small carry helper used by the shift-add multiply step.
package mult_div_sequencer_pkg;

  // ALU control codes understood by the shared ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Operation selected by the op input
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  // Sequencer states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Carry out of an unsigned 32-bit add, recovered from the wrapped sum
  function automatic logic add_carry(input logic [31:0] sum, input logic [31:0] addend);
    return (sum < addend);
  endfunction

endpackage

// File: rtl/mult_div_sequencer_alu.sv
// Existing 32-bit Execute-stage ALU. The sequencer only uses ADD and
// SUB; the remaining functions are kept so the block stays drop-in.
module mult_div_sequencer_alu
  import mult_div_sequencer_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  ctrl_i,
  output logic [31:0] y_o
);

  // Combinational result selected by the control code
  always_comb begin
    y_o = 32'd0;
    case (ctrl_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_SLT: y_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      default: y_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative unsigned MULTU/DIVU unit. One ALU add or subtract per clock,
// 32 steps per operation, results written to the HI/LO pair on the edge
// that enters DONE. busy tells the hazard unit to stall MFHI/MFLO.
// The ALU datapath is fixed at 32 bits, so WIDTH must stay 32.
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             op_q, op_d;
  // Operand added (multiplicand) or subtracted (divisor) every step
  logic [WIDTH-1:0] opnd_q, opnd_d;
  // Working pair: acc/mplr for MULTU, rem/quot for DIVU
  logic [WIDTH-1:0] whi_q, whi_d, wlo_q, wlo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0] alu_a_s, alu_y_s;
  logic [2:0]       alu_ctrl_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] sum_s, step_hi_s, step_lo_s;
  logic             carry_s, accept_s, launch_s;

  mult_div_sequencer_alu u_alu (
    .a_i    (alu_a_s),
    .b_i    (opnd_q),
    .ctrl_i (alu_ctrl_s),
    .y_o    (alu_y_s)
  );

  // One multiply or divide iteration computed from the working registers.
  // The remainder register only ever holds a value below the divisor, so
  // its top bit lives only in the shifted copy rem_sh_s.
  always_comb begin
    rem_sh_s   = {whi_q, wlo_q[WIDTH-1]};
    alu_a_s    = whi_q;
    alu_ctrl_s = ALU_ADD;
    sum_s      = whi_q;
    carry_s    = 1'b0;
    accept_s   = 1'b0;
    step_hi_s  = whi_q;
    step_lo_s  = wlo_q;
    case (op_q)
      OP_MULTU: begin
        alu_a_s    = whi_q;
        alu_ctrl_s = ALU_ADD;
        if (wlo_q[0]) begin
          sum_s   = alu_y_s;
          carry_s = add_carry(alu_y_s, opnd_q);
        end else begin
          sum_s   = whi_q;
          carry_s = 1'b0;
        end
        step_hi_s = {carry_s, sum_s[WIDTH-1:1]};
        step_lo_s = {sum_s[0], wlo_q[WIDTH-1:1]};
      end
      OP_DIVU: begin
        alu_a_s    = rem_sh_s[WIDTH-1:0];
        alu_ctrl_s = ALU_SUB;
        accept_s   = rem_sh_s[WIDTH] | (rem_sh_s[WIDTH-1:0] >= opnd_q);
        if (accept_s) begin
          step_hi_s = alu_y_s;
        end else begin
          step_hi_s = rem_sh_s[WIDTH-1:0];
        end
        step_lo_s = {wlo_q[WIDTH-2:0], accept_s};
      end
      default: begin
        step_hi_s = whi_q;
        step_lo_s = wlo_q;
      end
    endcase
  end

  // Next-state logic: launch, iterate, publish result, or abort on cancel
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    whi_d    = whi_q;
    wlo_d    = wlo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    launch_s = start & ~cancel;
    case (state_q)
      IDLE, DONE: begin
        if (launch_s) begin
          state_d = RUN;
          count_d = {CNT_W{1'b0}};
          op_d    = op;
          whi_d   = {WIDTH{1'b0}};
          if (op == OP_MULTU) begin
            opnd_d = a;
            wlo_d  = b;
          end else begin
            opnd_d = b;
            wlo_d  = a;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          whi_d   = step_hi_s;
          wlo_d   = step_lo_s;
          count_d = count_q + CNT_ONE;
          if (count_q == CNT_LAST) begin
            state_d = DONE;
            hi_d    = step_hi_s;
            lo_d    = step_lo_s;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, working and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= {CNT_W{1'b0}};
      op_q    <= OP_MULTU;
      opnd_q  <= {WIDTH{1'b0}};
      whi_q   <= {WIDTH{1'b0}};
      wlo_q   <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      whi_q   <= whi_d;
      wlo_q   <= wlo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer with a HI/LO scoreboard queue.
module tb_mult_div_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, op, cancel;
  logic [31:0] a, b, hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mult_div_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push expected {hi,lo} and pulse start for one cycle
  task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
    sb_q.push_back({eh, el});
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for done, checking busy duration, latency and result
  task automatic wait_done(input string tag);
    int bc = 0;
    int n  = 0;
    logic [63:0] e;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      step();
      n++;
    end
    chk({tag, " busy_cycles"}, 64'(bc), 64'd32);
    chk({tag, " latency"}, 64'(n), 64'd32);
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " busy_in_done"}, {63'd0, busy}, 64'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " hi"}, {32'd0, hi}, {32'd0, e[63:32]});
      chk({tag, " lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    end else begin
      chk({tag, " scoreboard"}, 64'(sb_q.size()), 64'd1);
    end
  endtask

  initial begin
    logic [31:0] x, y;
    logic [63:0] prod;
    logic        seen;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    cancel = 1'b0;
    a      = 32'd0;
    b      = 32'd0;
    repeat (2) step();
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    step();

    launch(1'b0, 32'd7, 32'd6, 32'd0, 32'd42);
    wait_done("mul7x6");
    step();
    chk("mul7x6 done_pulse", {63'd0, done}, 64'd0);

    launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    wait_done("mul_max");
    step();

    launch(1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    wait_done("div100_7");
    step();

    launch(1'b1, 32'h80000000, 32'd3, 32'd2, 32'h2AAAAAAA);
    wait_done("div_msb");
    step();

    launch(1'b1, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    wait_done("div_zero");
    step();

    for (int i = 0; i < 4; i++) begin
      x = $urandom();
      y = $urandom();
      prod = {32'd0, x} * {32'd0, y};
      launch(1'b0, x, y, prod[63:32], prod[31:0]);
      wait_done("rand_mul");
      step();
      y = $urandom_range(1000, 1);
      launch(1'b1, x, y, x % y, x / y);
      wait_done("rand_div");
      step();
    end

    // Establish hi=5, lo=9, then cancel a run at step 10
    launch(1'b1, 32'd95, 32'd10, 32'd5, 32'd9);
    wait_done("prime");
    step();
    op = 1'b0; a = 32'd3; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("cancel busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen = 1'b1;
      step();
    end
    chk("cancel no_done", {63'd0, seen}, 64'd0);
    chk("cancel hi", {32'd0, hi}, 64'd5);
    chk("cancel lo", {32'd0, lo}, 64'd9);

    // Reset in the middle of a run clears everything at once
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    chk("midreset busy", {63'd0, busy}, 64'd0);
    chk("midreset hi", {32'd0, hi}, 64'd0);
    chk("midreset lo", {32'd0, lo}, 64'd0);
    step();
    reset = 1'b0;
    step();

    // Back-to-back launch from the DONE cycle
    launch(1'b0, 32'd7, 32'd6, 32'd0, 32'd42);
    wait_done("b2b_first");
    launch(1'b0, 32'd9, 32'd9, 32'd0, 32'd81);
    wait_done("b2b_second");
    step();
    chk("b2b done_pulse", {63'd0, done}, 64'd0);

    // start together with cancel in IDLE is dropped
    start = 1'b1; cancel = 1'b1;
    step();
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel busy", {63'd0, busy}, 64'd0);
    step();
    chk("start_cancel busy2", {63'd0, busy}, 64'd0);
    chk("start_cancel done", {63'd0, done}, 64'd0);
    chk("idle_cancel lo", {32'd0, lo}, 64'd81);
    chk("idle_cancel hi", {32'd0, hi}, 64'd0);
    chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Iterative 32-cycle unsigned multiply/divide unit for the Execute stage. It writes the HI/LO register pair used by MULTU/DIVU and read by MFHI/MFLO.
- Sequences one internal ALU instance through add or subtract steps, one step per clock.
- Exposes busy to the hazard unit, which stalls dependent MFHI/MFLO reads and any new MULTU/DIVU while a run is in progress.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported because the ALU datapath is fixed at 32 bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch request from the ID/EX stage; a one-cycle pulse.
- op  input  1  0 = MULTU, 1 = DIVU; sampled with start.
- a  input  WIDTH  multiplicand or dividend (rs); sampled with start.
- b  input  WIDTH  multiplier or divisor (rt); sampled with start.
- cancel  input  1  pipeline flush; aborts the current operation.
- busy  output  1  high while the unit is in RUN.
- done  output  1  one-cycle completion pulse.
- hi  output  WIDTH  HI register: product[63:32] for MULTU, remainder for DIVU.
- lo  output  WIDTH  LO register: product[31:0] for MULTU, quotient for DIVU.

Behaviour:
- Reset: asynchronous. State goes to IDLE; busy=0, done=0, hi=0, lo=0, counter and all working registers cleared. Reset during RUN discards the operation with no partial update.
- States:
  - IDLE: start=1 and cancel=0 latches op, a and b, clears the accumulator, sets count=0, and moves to RUN.
  - RUN: one step per cycle, count incremented each cycle. When count reaches WIDTH-1, the step completes and the state moves to DONE. cancel=1 moves to IDLE; hi/lo keep their previous values.
  - DONE: done=1 for exactly this cycle. hi/lo were loaded on the edge that entered DONE. Next state is IDLE, or RUN if start=1 and cancel=0 (back-to-back launch).
- Latency: start sampled at edge E0 gives busy=1 in the cycles after E0 through E32. DONE is entered at E32, so done=1 and the new hi/lo are visible in the cycle after E32. Total is 33 cycles from start to result.
- start while in RUN is ignored; the hazard unit guarantees it is not issued.
- cancel and start in the same cycle: cancel wins, start is dropped.
- cancel in DONE or IDLE has no effect on hi/lo.
- MULTU, shift-add:
  - Working registers: acc (WIDTH bits), carry (1 bit), mplr (WIDTH bits, initialised to b).
  - Each step: if mplr[0]=1, the ALU computes acc+a with control 3'b010; carry is derived as (sum < a), unsigned. Otherwise the sum is acc and carry is 0.
  - {carry, sum, mplr} is then shifted right by 1 into {acc, mplr}.
  - Final result: hi = acc, lo = mplr.
- DIVU, restoring:
  - Working registers: rem (WIDTH+1 bits), quot (WIDTH bits, initialised to a).
  - Each step: {rem, quot} shifts left by 1. The ALU computes rem[WIDTH-1:0] - b with control 3'b110.
  - The subtraction is accepted if rem[WIDTH]=1 or rem[WIDTH-1:0] >= b (unsigned). If accepted, rem takes the difference and quot[0]=1; otherwise rem is unchanged and quot[0]=0.
  - Final result: hi = rem[WIDTH-1:0], lo = quot.
- Divide by zero: same 33-cycle latency, no special casing. Result is lo = 32'hFFFFFFFF and hi = a.
- All arithmetic is unsigned, and the ALU zero flag is unused.

Decomposition:
- Shared package/header holds:
  - ALU control constants: ALU_ADD = 3'b010, ALU_SUB = 3'b110.
  - Op encodings: OP_MULTU = 1'b0, OP_DIVU = 1'b1.
  - State encodings: IDLE, RUN, DONE (2 bits).
- Sub-module: the existing ALU, instantiated once for the per-step add/subtract.
- The FSM, counter and shift registers stay in this module.

Test Plan:
- reset, then start op=0 a=7 b=6 -> busy=1 for 32 cycles, done pulses at cycle 33, hi=0, lo=42.
- op=0 a=32'hFFFFFFFF b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises the carry path).
- op=1 a=100 b=7 -> lo=14, hi=2; then op=1 a=32'h80000000 b=3 -> lo=32'h2AAAAAAA, hi=2.
- op=1 a=32'h12345678 b=0 -> after 33 cycles lo=32'hFFFFFFFF, hi=32'h12345678.
- With prior hi=5, lo=9: start, then cancel at RUN step 10 -> busy=0 next cycle, done never pulses, hi=5, lo=9. Repeat with reset asserted mid-RUN -> hi=0, lo=0, busy=0 immediately.
- start asserted in the DONE cycle (7*6, then 9*9) -> done pulses twice 33 cycles apart, final lo=81. Check that start+cancel in IDLE produces no busy.
